// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sequencer.
//   state_t    - FSM state encoding (IDLE/SCAN/DONE, 2 bits)
//   CH_A..CH_D - channel index values, equal to the {s1,s0} select code
//   SETTLE_W   - settle counter width
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/mux_scan_sequencer_settle_counter.sv
// settle_counter: counts the cycles that one select code is held.
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   clear    - synchronous clear to 0 (has priority over enable)
//   enable   - advance the count; wraps to 0 after SETTLE-1
//   terminal - high while enabled and count == SETTLE-1
module settle_counter
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign terminal = enable && (r_cnt == LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: sweeps the 4:1 mux selects through channels a..d,
// samples mux_out once per channel and presents the 4-bit word with a
// valid/ready handshake.
//   clk, reset_n - clock (rising edge), asynchronous active-low reset
//   start        - request a sweep (honoured in IDLE and at the handshake)
//   mux_out      - output of the 4:1 mux being scanned
//   s0, s1       - registered mux select
//   data_out     - captured word, bit {s1,s0} = channel sampled with that select
//   valid, ready - output handshake
//   busy         - high in SCAN and DONE
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE      = 1,
  parameter bit          AUTO_REPEAT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ch, w_ch_nxt;
  logic [2:0] r_shadow, w_shadow_nxt;
  logic [3:0] r_data, w_data_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_term;
  logic       w_cnt_clear;
  logic       w_cnt_en;

  // Counter sits at 0 outside SCAN, so every sweep starts with a full settle.
  assign w_cnt_en    = (r_state == SCAN);
  assign w_cnt_clear = (r_state != SCAN);

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (w_cnt_clear),
    .enable   (w_cnt_en),
    .terminal (w_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch     <= CH_A;
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ch     <= w_ch_nxt;
      r_shadow <= w_shadow_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ch_nxt     = r_ch;
    w_shadow_nxt = r_shadow;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SCAN;
          w_ch_nxt    = CH_A;
        end
      end
      SCAN: begin
        if (w_term) begin
          // Channel d bypasses the shadow and lands directly in data_out.
          unique case (r_ch)
            CH_A: w_shadow_nxt[0] = mux_out;
            CH_B: w_shadow_nxt[1] = mux_out;
            CH_C: w_shadow_nxt[2] = mux_out;
            CH_D: begin
              w_data_nxt  = {mux_out, r_shadow};
              w_valid_nxt = 1'b1;
              w_state_nxt = DONE;
            end
          endcase
          if (r_ch != CH_D) w_ch_nxt = r_ch + 2'd1;
        end
      end
      DONE: begin
        if (r_valid && ready) begin
          w_valid_nxt = 1'b0;
          w_ch_nxt    = CH_A;
          w_state_nxt = (AUTO_REPEAT || start) ? SCAN : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ch_nxt    = CH_A;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign s0       = r_ch[0];
  assign s1       = r_ch[1];
  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: three instances (SETTLE=1, SETTLE=3,
// SETTLE=2 with AUTO_REPEAT) each driving its own gate-level 4:1 mux.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  start;
  logic [2:0]  ready;
  logic [11:0] chin;
  wire  [2:0]  mo;
  logic [2:0]  s0, s1, valid, busy;
  logic [11:0] dout;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned ST = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    localparam bit          AR = (g == 2);
    wire ns0, ns1, t0, t1, t2, t3;
    not (ns0, s0[g]);
    not (ns1, s1[g]);
    and (t0, chin[4*g+0], ns1, ns0);
    and (t1, chin[4*g+1], ns1, s0[g]);
    and (t2, chin[4*g+2], s1[g], ns0);
    and (t3, chin[4*g+3], s1[g], s0[g]);
    or  (mo[g], t0, t1, t2, t3);

    mux_scan_sequencer #(.SETTLE(ST), .AUTO_REPEAT(AR)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start[g]),
      .mux_out  (mo[g]),
      .s0       (s0[g]),
      .s1       (s1[g]),
      .data_out (dout[4*g +: 4]),
      .valid    (valid[g]),
      .ready    (ready[g]),
      .busy     (busy[g])
    );
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb[$];

  typedef struct {
    logic [3:0] chin;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sel(input int i);
    return int'({s1[i], s0[i]});
  endfunction

  task automatic launch(input int i, input logic [3:0] c, input logic [3:0] e);
    chin[4*i +: 4] = c;
    sb.push_back(e);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  // Called right after the edge that started the sweep; poke >= 0 pulses
  // start at that sample index to check it is ignored mid-sweep.
  task automatic wait_valid(input int i, input int st, input int poke);
    int n;
    logic [3:0] e;
    n = 0;
    while (!valid[i] && n < 4*st + 8) begin
      if (n < 4*st) chk("sel_sweep", sel(i), n / st);
      chk("busy_sweep", int'(busy[i]), 1);
      start[i] = (n == poke);
      tick();
      n++;
    end
    start[i] = 1'b0;
    chk("latency", n, 4*st);
    chk("valid_rise", int'(valid[i]), 1);
    chk("sel_done", sel(i), 3);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got word %0h, expected none queued", dout[4*i +: 4]);
    end else begin
      e = sb.pop_front();
      chk("data_out", int'(dout[4*i +: 4]), int'(e));
    end
  endtask

  task automatic hs(input int i, input logic st_in);
    ready[i] = 1'b1;
    start[i] = st_in;
    tick();
    ready[i] = 1'b0;
    start[i] = 1'b0;
    chk("hs_valid_low", int'(valid[i]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1101, 4'b1101};
    tbl[1] = '{4'b0000, 4'b0000};
    tbl[2] = '{4'b1111, 4'b1111};
    tbl[3] = '{4'b0110, 4'b0110};
    tbl[4] = '{4'b1001, 4'b1001};
    tbl[5] = '{4'b1010, 4'b1010};

    reset_n = 1'b0;
    start   = '0;
    ready   = '0;
    chin    = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++)
      chk("reset_state", int'({s1[i], s0[i], valid[i], busy[i], dout[4*i +: 4]}), 0);
    reset_n = 1'b1;
    tick();

    // Basic sweeps, SETTLE=1
    for (int k = 0; k < 6; k++) begin
      launch(0, tbl[k].chin, tbl[k].exp);
      wait_valid(0, 1, -1);
      hs(0, 1'b0);
      chk("idle_busy", int'(busy[0]), 0);
      chk("idle_sel", sel(0), 0);
    end

    // SETTLE=3
    launch(1, 4'b0110, 4'b0110);
    wait_valid(1, 3, -1);
    hs(1, 1'b0);
    chk("s3_idle_busy", int'(busy[1]), 0);

    // Backpressure: inputs toggle, start pulses, word must hold
    launch(0, 4'b1011, 4'b1011);
    wait_valid(0, 1, -1);
    for (int j = 0; j < 5; j++) begin
      chin[3:0] = 4'($urandom);
      start[0]  = (j % 2 == 0);
      tick();
      chk("bp_valid", int'(valid[0]), 1);
      chk("bp_data", int'(dout[3:0]), 4'b1011);
      chk("bp_sel", sel(0), 3);
    end
    start[0] = 1'b0;
    hs(0, 1'b0);
    chk("bp_busy_after", int'(busy[0]), 0);
    chk("bp_sel_after", sel(0), 0);
    tick();
    chk("bp_start_not_queued", int'(busy[0]), 0);

    // ready while idle has no effect
    ready[0] = 1'b1;
    tick();
    tick();
    ready[0] = 1'b0;
    chk("idle_ready_busy", int'(busy[0]), 0);
    chk("idle_ready_valid", int'(valid[0]), 0);

    // Back-to-back via start at the handshake
    launch(0, 4'b0011, 4'b0011);
    wait_valid(0, 1, -1);
    chin[3:0] = 4'b1100;
    sb.push_back(4'b1100);
    hs(0, 1'b1);
    chk("b2b_sel", sel(0), 0);
    chk("b2b_busy", int'(busy[0]), 1);
    wait_valid(0, 1, -1);
    hs(0, 1'b0);

    // Back-to-back via AUTO_REPEAT, SETTLE=2
    launch(2, 4'b1001, 4'b1001);
    wait_valid(2, 2, -1);
    chin[11:8] = 4'b0101;
    sb.push_back(4'b0101);
    hs(2, 1'b0);
    chk("auto_sel", sel(2), 0);
    chk("auto_busy", int'(busy[2]), 1);
    wait_valid(2, 2, -1);

    // start pulsed at ch=1 must not restart the sweep
    launch(0, 4'b1110, 4'b1110);
    wait_valid(0, 1, 1);
    hs(0, 1'b0);

    // Asynchronous reset while ch=2
    chin[3:0] = 4'b1111;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    chk("rst_pre_sel", sel(0), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_0", int'({s1[0], s0[0], valid[0], busy[0], dout[3:0]}), 0);
    chk("rst_async_2", int'({s1[2], s0[2], valid[2], busy[2], dout[11:8]}), 0);
    tick();
    reset_n = 1'b1;
    tick();
    launch(0, 4'b0010, 4'b0010);
    wait_valid(0, 1, -1);
    hs(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
